// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative MULT/MULTU/DIV/DIVU engine for the EX stage; owns HI/LO.
//   One multiplier/quotient bit per CALC cycle, sign fix-up and HI/LO
//   write in a single FIX cycle. MTHI/MTLO write HI/LO directly from IDLE.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op           one-cycle request (sampled in IDLE only), opcode
//   operand_a/b         rs / rt values
//   flush               abort in-flight op (and suppress start in IDLE)
//   busy, done          op in flight / HI-LO just took a MULT/DIV result
//   hi, lo              architectural HI/LO
module mult_div_unit #(
    parameter int BUS_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [BUS_SIZE-1:0] operand_a,
    input  logic [BUS_SIZE-1:0] operand_b,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [BUS_SIZE-1:0] hi,
    output logic [BUS_SIZE-1:0] lo
);
    localparam int CW = $clog2(BUS_SIZE);
    localparam int W2 = 2 * BUS_SIZE;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;

    // p: multiply = {partial sum, remaining multiplier bits}
    //    divide   = {partial remainder, dividend/quotient shift bits}
    logic [W2-1:0]       p;
    logic [BUS_SIZE-1:0] bm;      // multiplicand or divisor magnitude
    logic [CW-1:0]       cnt;
    logic                is_div, neg_q, neg_r;

    // Request decode
    logic                is_sgn, a_neg, b_neg, div0, accept;
    logic [BUS_SIZE-1:0] a_mag, b_mag;

    assign is_sgn = ~op[0];
    assign a_neg  = is_sgn & operand_a[BUS_SIZE-1];
    assign b_neg  = is_sgn & operand_b[BUS_SIZE-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign a_mag  = a_neg ? -operand_a : operand_a;
    assign b_mag  = b_neg ? -operand_b : operand_b;
    assign div0   = op[1] & (operand_b == '0);
    assign accept = (state == IDLE) & start & ~flush & ~op[2];
    assign busy   = (state != IDLE);

    // One shift-add multiply step
    logic [BUS_SIZE:0] msum;
    logic [W2-1:0]     p_mul;
    assign msum  = {1'b0, p[W2-1:BUS_SIZE]} + (p[0] ? {1'b0, bm} : '0);
    assign p_mul = {msum, p[BUS_SIZE-1:1]};

    // One restoring divide step on a 33-bit partial remainder
    logic [BUS_SIZE:0]   dshift;
    logic [BUS_SIZE+1:0] ddiff;
    logic [W2-1:0]       p_div;
    assign dshift = {p[W2-1:BUS_SIZE], p[BUS_SIZE-1]};
    assign ddiff  = {1'b0, dshift} - {2'b00, bm};
    assign p_div  = ddiff[BUS_SIZE+1] ? {dshift[BUS_SIZE-1:0], p[BUS_SIZE-2:0], 1'b0}
                                      : {ddiff[BUS_SIZE-1:0], p[BUS_SIZE-2:0], 1'b1};

    // Sign fix-up
    logic [W2-1:0]       res_mul;
    logic [BUS_SIZE-1:0] q_fix, r_fix;
    assign res_mul = neg_q ? -p : p;
    assign q_fix   = neg_q ? -p[BUS_SIZE-1:0] : p[BUS_SIZE-1:0];
    assign r_fix   = neg_r ? -p[W2-1:BUS_SIZE] : p[W2-1:BUS_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div0 ? FIX : CALC;
            CALC:    if (cnt == CW'(BUS_SIZE - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= '0;
            bm     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (op == 3'b100) hi <= operand_a;
                        else if (op == 3'b101) lo <= operand_a;
                        else if (accept) begin
                            cnt <= '0;
                            bm  <= op[1] ? b_mag : a_mag;
                            if (div0) begin
                                // Preload the fixed divide-by-zero result and
                                // let FIX write it as a plain {hi,lo} value.
                                p      <= {operand_a, {BUS_SIZE{1'b1}}};
                                is_div <= 1'b0;
                                neg_q  <= 1'b0;
                                neg_r  <= 1'b0;
                            end else begin
                                p      <= {{BUS_SIZE{1'b0}}, (op[1] ? a_mag : b_mag)};
                                is_div <= op[1];
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                            end
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        p   <= is_div ? p_div : p_mul;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= res_mul[W2-1:BUS_SIZE];
                            lo <= res_mul[BUS_SIZE-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    logic        clk, rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nchk = 0;
    int nerr = 0;

    mult_div_unit #(.BUS_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of an op, from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (o[1] && b == 0) return {a, 32'hFFFFFFFF};
        case (o[1:0])
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
        endcase
    endfunction

    // Behavioural model: cycles remaining until the result lands
    int          m_left;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_hi = 0; m_lo = 0; m_res = 0;
        end else begin
            m_done = 0;
            if (m_left != 0) begin
                if (flush) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = m_res;
                        m_done = 1;
                    end
                end
            end else if (start && !flush) begin
                if (op == 3'd4) m_hi = operand_a;
                else if (op == 3'd5) m_lo = operand_a;
                else if (op < 3'd4) begin
                    m_res  = ref_res(op, operand_a, operand_b);
                    m_left = (op[1] && operand_b == 0) ? 1 : 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy", {63'h0, busy}, {63'h0, (m_left != 0)});
            chk("cyc_done", {63'h0, done}, {63'h0, m_done});
            chk("cyc_hilo", {hi, lo}, {m_hi, m_lo});
        end
    end

    // Issue at posedge+2, return at posedge+2 after done; checks literals
    task automatic run_op(string nm, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                          logic [31:0] eh, logic [31:0] el, int lat);
        int cyc = 0;
        int bcyc = 0;
        bit seen = 0;
        start = 1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        bcyc += int'(busy);
        #1 start = 0;
        while (cyc < 40 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1;
            else bcyc += int'(busy);
        end
        #1;
        chk({nm, "_latency"}, 64'(cyc), 64'(lat));
        chk({nm, "_busycyc"}, 64'(bcyc), 64'(lat));
        chk({nm, "_hilo"}, {hi, lo}, {eh, el});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        bit dseen;
        rst_n = 0; start = 0; flush = 0; op = 0; operand_a = 0; operand_b = 0;
        #12;
        chk("rst_state", {30'h0, busy, done, hi, lo}, 64'h0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #2;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        run_op("mult_min",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
        run_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("divu",      3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 33);
        run_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
        run_op("divu_zero", 3'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1);

        // Second start while busy ignored; flush aborts with no write
        start = 1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd5;
        @(posedge clk); #2 start = 0;
        repeat (4) @(posedge clk);
        #2 start = 1; op = 3'd3; operand_a = 32'd9; operand_b = 32'd1;
        @(posedge clk); #2 start = 0;
        repeat (4) @(posedge clk);
        #2 flush = 1;
        @(posedge clk); #1;
        chk("flush_busy", {63'h0, busy}, 64'h0);
        chk("flush_hilo", {hi, lo}, {32'h5, 32'hFFFFFFFF});
        #1 flush = 0;
        dseen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dseen = 1;
        end
        chk("flush_nodone", {63'h0, dseen}, 64'h0);

        @(posedge clk); #2;
        start = 1; op = 3'd4; operand_a = 32'h1234;
        @(posedge clk); #1;
        chk("mthi", {30'h0, busy, done, hi}, {32'h0, 32'h1234});
        #1 op = 3'd5; operand_a = 32'hABCD;
        @(posedge clk); #1;
        chk("mtlo", {hi, lo}, {32'h1234, 32'hABCD});
        #1 op = 3'd6; operand_a = 32'h5555;
        @(posedge clk); #1;
        chk("op_nop", {31'h0, busy, hi}, {32'h0, 32'h1234});
        #1 start = 0;

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #2;
        start = 1; op = 3'd1; operand_a = 32'h11; operand_b = 32'h22;
        @(posedge clk); #2 start = 0;
        repeat (10) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst", {30'h0, busy, done, hi, lo}, 64'h0);
        @(negedge clk) rst_n = 1;

        // Random traffic checked cycle-by-cycle against the model
        repeat (3000) begin
            @(posedge clk); #2;
            start     = ($urandom_range(0, 99) < 30);
            op        = 3'($urandom_range(0, 7));
            operand_a = pick();
            operand_b = pick();
            flush     = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #2 start = 0; flush = 0;
        repeat (40) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
